// File: rtl/processor_v2.sv
// processor_v2: 18-bit single-issue core with branch/call/return/halt and a stalling
// request/ready data-memory port; ip, lr and the eight registers live here.
module processor_v2 #(
  parameter int ADDR_SIZE  = 18,
  parameter int WORD_SIZE  = 18,
  parameter int RESET_ADDR = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [ADDR_SIZE-1:0] code_addr,
  input  logic [17:0]          code_word,
  output logic                 memory_request,
  output logic                 memory_write_enable,
  output logic [ADDR_SIZE-1:0] memory_addr,
  output logic [WORD_SIZE-1:0] memory_in,
  input  logic [WORD_SIZE-1:0] memory_out,
  input  logic                 memory_ready,
  output logic                 halted
);
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;
  state_t               r_state;
  logic [ADDR_SIZE-1:0] r_ip, r_lr, r_maddr;
  logic [WORD_SIZE-1:0] r_regs [8];
  logic [WORD_SIZE-1:0] r_mdata;
  logic [2:0]           r_mrx;
  logic                 r_mwe, r_halted;
  logic [3:0]           w_op;
  logic [2:0]           w_rx, w_ry;
  logic [WORD_SIZE-1:0] w_s8w, w_s11w, w_rxv, w_ryv, w_wval;
  logic [ADDR_SIZE-1:0] w_s8a, w_s11a, w_ip1, w_nip, w_ea;
  logic                 w_mem, w_wen, w_wait;
  assign w_op   = code_word[17:14];
  assign w_rx   = code_word[13:11];
  assign w_ry   = code_word[10:8];
  assign w_s8w  = WORD_SIZE'($signed(code_word[7:0]));
  assign w_s11w = WORD_SIZE'($signed(code_word[10:0]));
  assign w_s8a  = ADDR_SIZE'($signed(code_word[7:0]));
  assign w_s11a = ADDR_SIZE'($signed(code_word[10:0]));
  assign w_rxv  = r_regs[w_rx];
  assign w_ryv  = r_regs[w_ry];
  assign w_ea   = ADDR_SIZE'(w_ryv + w_s8w);
  assign w_ip1  = r_ip + ADDR_SIZE'(1);
  assign w_mem  = w_op == 4'd3 || w_op == 4'd4;
  assign w_wait = r_state == S_WAIT;
  assign w_wen  = (w_op inside {4'd0, 4'd1, 4'd2, 4'd8}) || (w_op == 4'd3 && memory_ready);
  assign w_wval = w_op == 4'd0 ? w_ryv + w_s8w :
                  w_op == 4'd1 ? w_s11w :
                  w_op == 4'd2 ? w_s11w << 7 :
                  w_op == 4'd3 ? memory_out : WORD_SIZE'(r_lr);
  assign w_nip  = w_op == 4'd5 ? (w_rxv == '0 ? r_ip + w_s8a : w_ip1) :
                  w_op == 4'd6 ? r_ip + w_s11a :
                  w_op == 4'd7 ? r_lr : w_ip1;
  // gating with reset drops a pending request the instant reset asserts
  assign memory_request      = reset && (w_wait || (r_state == S_RUN && w_mem));
  assign memory_write_enable = memory_request && (w_wait ? r_mwe : w_op == 4'd4);
  assign memory_addr         = w_wait ? r_maddr : w_ea;
  assign memory_in           = w_wait ? r_mdata : w_rxv;
  assign code_addr           = r_ip;
  assign halted              = r_halted;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_state  <= S_RUN;
      r_ip     <= ADDR_SIZE'(RESET_ADDR);
      r_lr     <= '0;
      r_halted <= 1'b0;
      r_maddr  <= '0;
      r_mdata  <= '0;
      r_mrx    <= '0;
      r_mwe    <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else
      case (r_state)
        S_RUN: begin
          if (w_wen) r_regs[w_rx] <= w_wval;
          if (w_op == 4'd9) r_lr <= ADDR_SIZE'(w_rxv);
          if (w_op == 4'd6) r_lr <= w_ip1;
          if (w_op == 4'd15) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (w_mem && !memory_ready) begin
            r_state <= S_WAIT;
            r_maddr <= w_ea;
            r_mdata <= w_rxv;
            r_mrx   <= w_rx;
            r_mwe   <= w_op == 4'd4;
          end else r_ip <= w_nip;
        end
        S_WAIT:
          if (memory_ready) begin
            if (!r_mwe) r_regs[r_mrx] <= memory_out;
            r_ip    <= w_ip1;
            r_state <= S_RUN;
          end
        default: ;
      endcase
endmodule
